vga_scan: RTL and testbench
===========================

# vga_scan

Pixel-clock VGA scan engine for the game display: generates the 640x480@60 Hz raster, drives the shared `row_addr`/`col_addr` bus read by every sprite renderer, and samples their combined 1-bit `px` reply into 12-bit RGB with aligned sync outputs. It also produces the `fresh` frame strobe whose falling edge sprite modules use to advance their positions once per frame. It sits between the sprite renderers and the board VGA connector.

## Interface
- `PX_LAT`, 1: cycles from address change to valid `px` (sprites register `px` once).
- `FG_RGB`, 12'h000: colour for `px`=1.
- `BG_RGB`, 12'hFFF: colour for `px`=0 in the active area.
- `clk` input 1: pixel clock, 25 MHz, driven from `clkdiv[0]`.
- `RESET` input 1: asynchronous, active-high reset.
- `px` input 1: combined sprite pixel for the address issued `PX_LAT` cycles earlier.
- `row_addr` output 9: current scan row, meaningful for rows 0..479.
- `col_addr` output 10: current scan column, meaningful for columns 0..639.
- `fresh` output 1: high during vertical blanking; falls at the start of row 0.
- `hs`, `vs` output 1 each: active-low horizontal and vertical sync.
- `rgb` output 12: {R[3:0],G[3:0],B[3:0]}; 0 outside the active area.

## Operation
- `h_cnt` counts 0..799 and wraps to 0. On wrap, `v_cnt` counts 0..524 and wraps to 0.
- Both counters are 10-bit registers.
- `col_addr` = `h_cnt`.
- `row_addr` = `v_cnt[8:0]`. Values for `v_cnt` >= 512 alias to 0..12; this is harmless because blanking masks them.
- `active` = (`h_cnt` < 640) && (`v_cnt` < 480).
- `hs_raw` = 0 for `h_cnt` in 656..751.
- `vs_raw` = 0 for `v_cnt` in 490..491.
- `fresh` is a registered copy of (`v_cnt` >= 480). It is not delayed. Its falling edge occurs one cycle after the `v_cnt` 524 to 0 wrap.
- `active`, `hs_raw` and `vs_raw` pass through a delay line of `PX_LAT` stages, aligning them with `px`.
- Output stage, one register: `rgb` = delayed active ? (`px` ? `FG_RGB` : `BG_RGB`) : 0.
- `hs` and `vs` are registered from their delayed versions in the same cycle as `rgb`.
- Reset values: counters 0, `fresh` 0, `hs` 1, `vs` 1, `rgb` 0, all delay stages inactive (active 0, syncs 1).
- Reset mid-frame clears everything immediately. The raster restarts at (0,0) on the first clock after deassertion; no partial sync pulse is completed.

## Timing
- Address to `rgb`/`hs`/`vs` latency is `PX_LAT`+1 cycles: 2 by default. The counter value issued at edge t appears on the outputs after edge t+2.
- Line period is 800 cycles. Frame period is 420000 cycles. `fresh` is high for 45 lines (36000 cycles) per frame.
- `hs` low 96 cycles per line. `vs` low 1600 cycles per frame. Both are active-low throughout.
- `px` is sampled once per cycle. No handshake; `px` is assumed valid exactly `PX_LAT` cycles after the address.

## Configuration
- `VGA_SCAN_BORDER_EN` defined: active pixels with `h_cnt` in {0,639} or `v_cnt` in {0,479} output 12'hF00 regardless of `px`. This is for monitor alignment.
- Not defined: no border logic; `rgb` follows `px` only.

## Structure
- Shared package `vga_pkg` holds the timing constants: H_ACTIVE 640, H_FP 16, H_SYNC 96, H_TOTAL 800, V_ACTIVE 480, V_FP 10, V_SYNC 2, V_TOTAL 525.
- `vga_pkg` also holds the 12-bit `rgb_t` typedef.
- One sub-module, `vga_delay_line`, parameterised by depth and width, delays {active, hs, vs}.

## Test plan
- Reset: assert `RESET` mid-line at `h_cnt`=300 -> `hs`=`vs`=1, `rgb`=0, `fresh`=0 immediately. After release, `col_addr` reads 1, `row_addr` reads 0 after the first edge.
- Wrap: run 800 cycles from reset -> `col_addr` 799 to 0 and `row_addr` 0 to 1 on the same edge. After 420000 cycles `row_addr` returns to 0.
- Sync: `hs` low exactly 96 cycles, starting 2 cycles after `col_addr`=656. `vs` low for lines 490..491, delayed 2 cycles.
- `px` alignment: drive `px`=1 only when the address 1 cycle earlier was (100,50) -> `rgb`=`FG_RGB` for exactly one cycle, 2 cycles after (100,50) is issued; `BG_RGB` elsewhere in the active area.
- Blanking: hold `px`=1 constantly -> `rgb`=0 whenever the delayed column >= 640 or row >= 480.
- `fresh`: rises with `row_addr`=480 (col 0) and falls one cycle after the 524 to 0 wrap. Toggles once per 420000 cycles.

Source files
------------

// File: rtl/vga_pkg.sv
// Raster timing constants and pixel colour type for the VGA scan engine.
// VGA_SCAN_BORDER_EN widens the sync delay line to carry the border flag.
package vga_pkg;

   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned H_FP     = 16;
   localparam int unsigned H_SYNC   = 96;
   localparam int unsigned H_TOTAL  = 800;
   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned V_FP     = 10;
   localparam int unsigned V_SYNC   = 2;
   localparam int unsigned V_TOTAL  = 525;

   localparam int unsigned CNT_W = 10;
   localparam int unsigned ROW_W = 9;
   localparam int unsigned RGB_W = 12;

   typedef logic [RGB_W-1:0] rgb_t;

   localparam rgb_t BORDER_RGB = 12'hF00;

   // Delay line bit layout: [0] active, [1] hs, [2] vs, [3] border (optional)
`ifdef VGA_SCAN_BORDER_EN
   localparam int unsigned DL_W = 4;
   localparam logic [DL_W-1:0] DL_RST = 4'b0110;
`else
   localparam int unsigned DL_W = 3;
   localparam logic [DL_W-1:0] DL_RST = 3'b110;
`endif

endpackage

// File: rtl/vga_scan_if.sv
// Shared scan bus: address broadcast to sprite renderers, pixel reply, and VGA outputs.
interface vga_scan_if;
   import vga_pkg::*;

   logic             px;
   logic [ROW_W-1:0] row_addr;
   logic [CNT_W-1:0] col_addr;
   logic             fresh;
   logic             hs;
   logic             vs;
   rgb_t             rgb;

   modport master (
      input  px,
      output row_addr, col_addr, fresh, hs, vs, rgb
   );

   modport slave (
      output px,
      input  row_addr, col_addr, fresh, hs, vs, rgb
   );
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth register pipeline with a configurable reset value per bit.
module vga_delay_line #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned WIDTH = 3,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   generate
      if (DEPTH == 0) begin : g_bypass
         assign q_o = d_i;
      end else begin : g_pipe
         logic [WIDTH-1:0] stage_q [DEPTH];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= RST_VAL;
            end else begin
               stage_q[0] <= d_i;
               for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
            end
         end

         assign q_o = stage_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_scan.sv
// 640x480@60 raster generator: broadcasts scan address, maps the sprite pixel reply to RGB.
// Optional VGA_SCAN_BORDER_EN paints a one-pixel red frame on the active area edges.
module vga_scan
   import vga_pkg::*;
#(
   parameter int unsigned PX_LAT = 1,
   parameter rgb_t        FG_RGB = 12'h000,
   parameter rgb_t        BG_RGB = 12'hFFF
) (
   input  logic       clk,
   input  logic       RESET,
   vga_scan_if.master bus
);

   logic [CNT_W-1:0] h_q, h_d;
   logic [CNT_W-1:0] v_q, v_d;
   logic             fresh_q;
   logic             hs_q;
   logic             vs_q;
   rgb_t             rgb_q, rgb_d;

   logic             active_c;
   logic             hs_raw_c;
   logic             vs_raw_c;
   logic [DL_W-1:0]  dl_in_c;
   logic [DL_W-1:0]  dl_out_c;

   // Raster counters: column wraps every line, row advances on column wrap
   always_comb begin
      h_d = h_q + CNT_W'(1);
      v_d = v_q;
      if (h_q == CNT_W'(H_TOTAL - 1)) begin
         h_d = '0;
         v_d = (v_q == CNT_W'(V_TOTAL - 1)) ? '0 : v_q + CNT_W'(1);
      end
   end

   assign active_c = (h_q < CNT_W'(H_ACTIVE)) && (v_q < CNT_W'(V_ACTIVE));
   assign hs_raw_c = !((h_q >= CNT_W'(H_ACTIVE + H_FP)) &&
                       (h_q <  CNT_W'(H_ACTIVE + H_FP + H_SYNC)));
   assign vs_raw_c = !((v_q >= CNT_W'(V_ACTIVE + V_FP)) &&
                       (v_q <  CNT_W'(V_ACTIVE + V_FP + V_SYNC)));

`ifdef VGA_SCAN_BORDER_EN
   logic border_c;
   assign border_c = (h_q == '0) || (h_q == CNT_W'(H_ACTIVE - 1)) ||
                     (v_q == '0) || (v_q == CNT_W'(V_ACTIVE - 1));
   assign dl_in_c  = {border_c, vs_raw_c, hs_raw_c, active_c};
`else
   assign dl_in_c  = {vs_raw_c, hs_raw_c, active_c};
`endif

   // Align blanking and syncs with the sprite pixel reply
   vga_delay_line #(
      .DEPTH   (PX_LAT),
      .WIDTH   (DL_W),
      .RST_VAL (DL_RST)
   ) u_delay (
      .clk (clk),
      .rst (RESET),
      .d_i (dl_in_c),
      .q_o (dl_out_c)
   );

   always_comb begin
      rgb_d = '0;
      if (dl_out_c[0]) begin
         rgb_d = bus.px ? FG_RGB : BG_RGB;
`ifdef VGA_SCAN_BORDER_EN
         if (dl_out_c[3]) rgb_d = BORDER_RGB;
`endif
      end
   end

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         h_q     <= '0;
         v_q     <= '0;
         fresh_q <= 1'b0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         rgb_q   <= '0;
      end else begin
         h_q     <= h_d;
         v_q     <= v_d;
         fresh_q <= (v_q >= CNT_W'(V_ACTIVE));
         hs_q    <= dl_out_c[1];
         vs_q    <= dl_out_c[2];
         rgb_q   <= rgb_d;
      end
   end

   assign bus.col_addr = h_q;
   assign bus.row_addr = v_q[ROW_W-1:0];
   assign bus.fresh    = fresh_q;
   assign bus.hs       = hs_q;
   assign bus.vs       = vs_q;
   assign bus.rgb      = rgb_q;

endmodule

// File: tb/tb_vga_scan.sv
// Directed bench for vga_scan: reset, line wrap and hsync, sprite pixel alignment, blanking, frame timing.
`timescale 1ns/1ps
module tb_vga_scan;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   int   n     = 0;
   logic pxv   = 1'b0;

   vga_scan_if bus ();

   vga_scan dut (
      .clk   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic int eh(int k);
      return k % 800;
   endfunction

   function automatic int ev(int k);
      return (k / 800) % 525;
   endfunction

   // Expected {row, col, hs, vs, fresh, rgb} after edge k, given px sampled at that edge
   function automatic logic [33:0] exp_vec(int k, logic p);
      logic [8:0]  r;
      logic [9:0]  c;
      logic        h, v, f;
      logic [11:0] x;
      int          d;
      r = 9'(ev(k));
      c = 10'(eh(k));
      d = k - 2;
      h = 1'b1;
      v = 1'b1;
      x = 12'h000;
      if (d >= 0) begin
         h = !(eh(d) >= 656 && eh(d) <= 751);
         v = !(ev(d) == 490 || ev(d) == 491);
         if (eh(d) < 640 && ev(d) < 480) x = p ? 12'h000 : 12'hFFF;
      end
      f = (k >= 1) && (ev(k - 1) >= 480);
      return {r, c, h, v, f, x};
   endfunction

   function automatic logic [33:0] got_vec();
      return {bus.row_addr, bus.col_addr, bus.hs, bus.vs, bus.fresh, bus.rgb};
   endfunction

   task automatic step();
      @(posedge clk);
      n++;
      @(negedge clk);
   endtask

   task automatic test_reset();
      int miss = 0;
      bus.px = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (bus.hs !== 1'b1)       begin bad++; $display("FAIL reset_hs got=%b exp=1", bus.hs); end
      total++; if (bus.vs !== 1'b1)       begin bad++; $display("FAIL reset_vs got=%b exp=1", bus.vs); end
      total++; if (bus.rgb !== 12'h000)   begin bad++; $display("FAIL reset_rgb got=%h exp=000", bus.rgb); end
      total++; if (bus.fresh !== 1'b0)    begin bad++; $display("FAIL reset_fresh got=%b exp=0", bus.fresh); end
      total++; if (bus.col_addr !== 10'd0) begin bad++; $display("FAIL reset_col got=%0d exp=0", bus.col_addr); end
      rst = 1'b0;
      n = 0;
      step();
      total++; if (bus.col_addr !== 10'd1) begin bad++; $display("FAIL first_col got=%0d exp=1", bus.col_addr); end
      total++; if (bus.row_addr !== 9'd0)  begin bad++; $display("FAIL first_row got=%0d exp=0", bus.row_addr); end
      while (n < 300) begin
         pxv = bus.px;
         step();
         if (got_vec() !== exp_vec(n, pxv)) begin
            if (miss == 0) $display("FAIL reset_sweep n=%0d got=%h exp=%h", n, got_vec(), exp_vec(n, pxv));
            miss++;
         end
      end
      total++; if (miss !== 0) begin bad++; $display("FAIL reset_sweep_count got=%0d exp=0", miss); end
      total++; if (bus.rgb !== 12'hFFF) begin bad++; $display("FAIL pre_reset_rgb got=%h exp=FFF", bus.rgb); end
      // Mid-line reset clears the outputs without waiting for a clock
      rst = 1'b1;
      #1;
      total++; if (bus.rgb !== 12'h000)    begin bad++; $display("FAIL midreset_rgb got=%h exp=000", bus.rgb); end
      total++; if (bus.col_addr !== 10'd0) begin bad++; $display("FAIL midreset_col got=%0d exp=0", bus.col_addr); end
      total++; if ({bus.hs, bus.vs, bus.fresh} !== 3'b110) begin
         bad++; $display("FAIL midreset_sync got=%b exp=110", {bus.hs, bus.vs, bus.fresh});
      end
      @(negedge clk);
      rst = 1'b0;
      n = 0;
   endtask

   task automatic test_line_wrap_sync();
      int miss = 0;
      int hs_low = 0;
      bus.px = 1'b0;
      while (n < 802) begin
         pxv = bus.px;
         step();
         if (got_vec() !== exp_vec(n, pxv)) begin
            if (miss == 0) $display("FAIL line_sweep n=%0d got=%h exp=%h", n, got_vec(), exp_vec(n, pxv));
            miss++;
         end
         if (bus.hs === 1'b0) hs_low++;
         if (n == 799) begin
            total++; if ({bus.row_addr, bus.col_addr} !== {9'd0, 10'd799}) begin
               bad++; $display("FAIL wrap_pre got=%0d,%0d exp=0,799", bus.row_addr, bus.col_addr);
            end
         end
         if (n == 800) begin
            total++; if ({bus.row_addr, bus.col_addr} !== {9'd1, 10'd0}) begin
               bad++; $display("FAIL wrap_post got=%0d,%0d exp=1,0", bus.row_addr, bus.col_addr);
            end
         end
         if (n == 657) begin
            total++; if (bus.hs !== 1'b1) begin bad++; $display("FAIL hs_before got=%b exp=1", bus.hs); end
         end
         if (n == 658) begin
            total++; if (bus.hs !== 1'b0) begin bad++; $display("FAIL hs_start got=%b exp=0", bus.hs); end
         end
         if (n == 754) begin
            total++; if (bus.hs !== 1'b1) begin bad++; $display("FAIL hs_end got=%b exp=1", bus.hs); end
         end
      end
      total++; if (hs_low !== 96)  begin bad++; $display("FAIL hs_width got=%0d exp=96", hs_low); end
      total++; if (miss !== 0)     begin bad++; $display("FAIL line_sweep_count got=%0d exp=0", miss); end
   endtask

   task automatic test_px_align();
      int miss = 0;
      int fg = 0;
      logic [8:0] cur_r = 9'd0, prev_r = 9'd0;
      logic [9:0] cur_c = 10'd0, prev_c = 10'd0;
      while (n < 52 * 800) begin
         // Sprite model: registers a hit for the address seen one cycle earlier
         bus.px = (prev_r == 9'd50) && (prev_c == 10'd100);
         pxv = bus.px;
         step();
         prev_r = cur_r;
         prev_c = cur_c;
         cur_r  = bus.row_addr;
         cur_c  = bus.col_addr;
         if (got_vec() !== exp_vec(n, pxv)) begin
            if (miss == 0) $display("FAIL px_sweep n=%0d got=%h exp=%h", n, got_vec(), exp_vec(n, pxv));
            miss++;
         end
         if (bus.rgb === 12'h000 && eh(n - 2) < 640 && ev(n - 2) < 480) fg++;
         if (n == 40101 || n == 40103) begin
            total++; if (bus.rgb !== 12'hFFF) begin bad++; $display("FAIL px_neighbour n=%0d got=%h exp=FFF", n, bus.rgb); end
         end
         if (n == 40102) begin
            total++; if (bus.rgb !== 12'h000) begin bad++; $display("FAIL px_hit got=%h exp=000", bus.rgb); end
         end
      end
      bus.px = 1'b0;
      total++; if (fg !== 1)   begin bad++; $display("FAIL px_fg_count got=%0d exp=1", fg); end
      total++; if (miss !== 0) begin bad++; $display("FAIL px_sweep_count got=%0d exp=0", miss); end
   endtask

   task automatic test_blanking();
      int miss = 0;
      int nonzero = 0;
      bus.px = 1'b1;
      while (n < 55 * 800) begin
         pxv = bus.px;
         step();
         if (got_vec() !== exp_vec(n, pxv)) begin
            if (miss == 0) $display("FAIL blank_sweep n=%0d got=%h exp=%h", n, got_vec(), exp_vec(n, pxv));
            miss++;
         end
         if (bus.rgb !== 12'h000) nonzero++;
      end
      bus.px = 1'b0;
      total++; if (nonzero !== 0) begin bad++; $display("FAIL blank_rgb_nonzero got=%0d exp=0", nonzero); end
      total++; if (miss !== 0)    begin bad++; $display("FAIL blank_sweep_count got=%0d exp=0", miss); end
   endtask

   task automatic test_frame();
      int miss = 0;
      int vs_low = 0;
      int fresh_hi = 0;
      int fresh_rise = 0;
      logic fresh_prev = 1'b0;
      bus.px = 1'b0;
      while (n < 420000 + 802) begin
         pxv = bus.px;
         step();
         if (got_vec() !== exp_vec(n, pxv)) begin
            if (miss == 0) $display("FAIL frame_sweep n=%0d got=%h exp=%h", n, got_vec(), exp_vec(n, pxv));
            miss++;
         end
         if (bus.vs === 1'b0) vs_low++;
         if (bus.fresh === 1'b1) fresh_hi++;
         if (bus.fresh === 1'b1 && fresh_prev === 1'b0) fresh_rise++;
         fresh_prev = bus.fresh;
         if (n == 384000) begin
            total++; if ({bus.row_addr, bus.col_addr} !== {9'd480, 10'd0}) begin
               bad++; $display("FAIL row480 got=%0d,%0d exp=480,0", bus.row_addr, bus.col_addr);
            end
         end
         if (n == 384001) begin
            total++; if (bus.fresh !== 1'b1) begin bad++; $display("FAIL fresh_rise got=%b exp=1", bus.fresh); end
         end
         if (n == 392001) begin
            total++; if (bus.vs !== 1'b1) begin bad++; $display("FAIL vs_before got=%b exp=1", bus.vs); end
         end
         if (n == 392002) begin
            total++; if (bus.vs !== 1'b0) begin bad++; $display("FAIL vs_start got=%b exp=0", bus.vs); end
         end
         if (n == 420000) begin
            total++; if ({bus.row_addr, bus.col_addr, bus.fresh} !== {9'd0, 10'd0, 1'b1}) begin
               bad++; $display("FAIL frame_wrap got=%0d,%0d,%b exp=0,0,1", bus.row_addr, bus.col_addr, bus.fresh);
            end
         end
         if (n == 420001) begin
            total++; if (bus.fresh !== 1'b0) begin bad++; $display("FAIL fresh_fall got=%b exp=0", bus.fresh); end
         end
      end
      total++; if (vs_low !== 1600)    begin bad++; $display("FAIL vs_width got=%0d exp=1600", vs_low); end
      total++; if (fresh_hi !== 36000) begin bad++; $display("FAIL fresh_width got=%0d exp=36000", fresh_hi); end
      total++; if (fresh_rise !== 1)   begin bad++; $display("FAIL fresh_rises got=%0d exp=1", fresh_rise); end
      total++; if (miss !== 0)         begin bad++; $display("FAIL frame_sweep_count got=%0d exp=0", miss); end
   endtask

   initial begin
      bus.px = 1'b0;
      test_reset();
      test_line_wrap_sync();
      test_px_align();
      test_blanking();
      test_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
